// File: rtl/dram_device_if.sv
// dram_device_if: SDRAM command/data bus between controller (master) and device (slave).
interface dram_device_if #(
  parameter int A_W = 11,
  parameter int D_W = 32,
  parameter int NB  = 4
);
  logic           CSn;
  logic           RASn;
  logic           CASn;
  logic [NB-1:0]  WEn;
  logic [A_W-1:0] A;
  logic [D_W-1:0] D;
  logic [D_W-1:0] Q;
  logic           VALID;
  logic           ERR;

  modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID, ERR);
  modport slave  (input CSn, RASn, CASn, WEn, A, D, output Q, VALID, ERR);
endinterface

// File: rtl/dram_device.sv
// dram_device: single-bank SDRAM cycle model. Tracks the open row, applies
// byte-masked writes and returns read data CL cycles after READ.
// Optional macro DRAM_TIMING_CHECK_EN enforces T_RCD / T_RP counters; without
// it ACT opens the row immediately and PRE closes it immediately.
module dram_device #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int T_RCD    = 5,
  parameter int T_RP     = 5,
  parameter int CL       = 5
) (
  input logic          clk,
  input logic          rst,
  dram_device_if.slave bus
);
  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int NB    = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVATING, S_ACTIVE, S_PRECHARGING} state_t;
  typedef enum logic [2:0] {C_NOP, C_ACT, C_PRE, C_RD, C_WR, C_BAD} cmd_t;

  state_t              r_state, w_state_nxt;
  cmd_t                w_cmd;
  logic [ROW_BITS-1:0] r_row;
  logic [AW-1:0]       w_addr;
  logic [31:0]         w_rd_data;
  logic                w_act, w_rd, w_wr, w_illegal;
  logic                r_err;
  logic [CL:1]         r_vld_pipe;
  logic [CL:1][31:0]   r_q_pipe;
  logic [31:0]         r_mem [0:DEPTH-1];

`ifdef DRAM_TIMING_CHECK_EN
  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CW   = $clog2(TMAX + 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
`endif

  assign w_addr    = {r_row, bus.A[COL_BITS-1:0]};
  assign w_rd_data = r_mem[w_addr];

  // Command decode; CSn high is always a NOP.
  always_comb begin
    w_cmd = C_NOP;
    if (!bus.CSn) begin
      if (!bus.RASn && bus.CASn && bus.WEn == 4'hF)      w_cmd = C_ACT;
      else if (!bus.RASn && bus.CASn && bus.WEn == 4'h0) w_cmd = C_PRE;
      else if (bus.RASn && !bus.CASn && bus.WEn == 4'hF) w_cmd = C_RD;
      else if (bus.RASn && !bus.CASn)                    w_cmd = C_WR;
      else                                               w_cmd = C_BAD;
    end
  end

  // Bank FSM next state; illegal commands leave the state alone and flag ERR.
  always_comb begin
    w_state_nxt = r_state;
    w_act       = 1'b0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_illegal   = (w_cmd == C_BAD);
`ifdef DRAM_TIMING_CHECK_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_cmd == C_ACT) begin
          w_act = 1'b1;
`ifdef DRAM_TIMING_CHECK_EN
          if (T_RCD > 1) begin
            w_state_nxt = S_ACTIVATING;
            w_cnt_nxt   = CW'(T_RCD - 1);
          end else begin
            w_state_nxt = S_ACTIVE;
          end
`else
          w_state_nxt = S_ACTIVE;
`endif
        end else if (w_cmd == C_RD || w_cmd == C_WR) begin
          w_illegal = 1'b1;
        end
      end
      S_ACTIVE: begin
        case (w_cmd)
          C_ACT: w_illegal = 1'b1;
          C_RD:  w_rd = 1'b1;
          C_WR:  w_wr = 1'b1;
          C_PRE: begin
`ifdef DRAM_TIMING_CHECK_EN
            if (T_RP > 1) begin
              w_state_nxt = S_PRECHARGING;
              w_cnt_nxt   = CW'(T_RP - 1);
            end else begin
              w_state_nxt = S_IDLE;
            end
`else
            w_state_nxt = S_IDLE;
`endif
          end
          default: ;
        endcase
      end
`ifdef DRAM_TIMING_CHECK_EN
      S_ACTIVATING, S_PRECHARGING: begin
        if (w_cmd != C_NOP) w_illegal = 1'b1;
        if (r_cnt <= CW'(1)) w_state_nxt = (r_state == S_ACTIVATING) ? S_ACTIVE : S_IDLE;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bank state, open row and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_act)     r_row <= bus.A[ROW_BITS-1:0];
      if (w_illegal) r_err <= 1'b1;
    end
  end

`ifdef DRAM_TIMING_CHECK_EN
  // Activate / precharge timer.
  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end
`endif

  // Byte-masked array write; contents intentionally have no reset.
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      for (int i = 0; i < NB; i++)
        if (!bus.WEn[i]) r_mem[w_addr][8*i +: 8] <= bus.D[8*i +: 8];
    end
  end

  // Read pipeline: data captured at the command edge, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_q_pipe   <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd;
      r_q_pipe[1]   <= w_rd ? w_rd_data : 32'h0;
      for (int s = 2; s <= CL; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_q_pipe[s]   <= r_q_pipe[s-1];
      end
    end
  end

  assign bus.VALID = r_vld_pipe[CL];
  assign bus.Q     = r_vld_pipe[CL] ? r_q_pipe[CL] : 32'h0;
  assign bus.ERR   = r_err;
endmodule

// File: tb/tb_dram_device.sv
// tb_dram_device: directed + random stimulus against a timestamp-based model
// of the SDRAM rules (open row, last ACT/PRE time, queue of pending reads).
module tb_dram_device;
  localparam int ROW_BITS = 11, COL_BITS = 10, T_RCD = 5, T_RP = 5, CL = 5;
`ifdef DRAM_TIMING_CHECK_EN
  localparam int RCD_M = T_RCD, RP_M = T_RP;
`else
  localparam int RCD_M = 0, RP_M = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  dram_device_if bus ();
  dram_device #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .T_RCD(T_RCD),
                .T_RP(T_RP), .CL(CL)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, n_valid = 0;
  logic [31:0] last_q;

  // reference model state
  bit m_open, m_err;
  int m_row, m_act_t, m_pre_t;
  logic [31:0] m_mem [int];
  logic [3:0]  m_kn  [int];
  typedef struct { int due; logic [31:0] data; logic [3:0] kn; } rd_t;
  rd_t m_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_row = 0; m_err = 0;
    m_act_t = -1000; m_pre_t = -1000;
    m_q.delete();
  endtask

  // One clock cycle: check outputs of this cycle, then present a command.
  task automatic tick(bit rv, bit csn, bit rasn, bit casn, logic [3:0] wen,
                      logic [10:0] a, logic [31:0] d);
    bit exp_v, idle, active;
    int key;
    rd_t r;
    logic [31:0] msk, old;
    logic [3:0] kn;
    @(negedge clk);
    exp_v = (m_q.size() > 0) && (m_q[0].due == cyc);
    chk("VALID", {31'b0, bus.VALID}, {31'b0, exp_v});
    if (exp_v) begin
      r = m_q.pop_front();
      for (int i = 0; i < 4; i++) msk[8*i +: 8] = {8{r.kn[i]}};
      chk("Q", bus.Q & msk, r.data & msk);
      last_q = bus.Q;
      n_valid++;
    end else begin
      chk("Q_idle", bus.Q, 32'h0);
    end
    chk("ERR", {31'b0, bus.ERR}, {31'b0, m_err});
    rst = rv; bus.CSn = csn; bus.RASn = rasn; bus.CASn = casn;
    bus.WEn = wen; bus.A = a; bus.D = d;
    if (!rv) model_reset();
    else if (!csn) begin
      idle   = !m_open && (cyc >= m_pre_t + RP_M);
      active =  m_open && (cyc >= m_act_t + RCD_M);
      key    = (m_row << COL_BITS) | int'(a[COL_BITS-1:0]);
      if (!rasn && casn && wen == 4'hF) begin
        if (idle) begin m_open = 1; m_row = int'(a); m_act_t = cyc; end
        else m_err = 1;
      end else if (!rasn && casn && wen == 4'h0) begin
        if (active) begin m_open = 0; m_pre_t = cyc; end
        else if (!idle) m_err = 1;
      end else if (rasn && !casn) begin
        if (!active) m_err = 1;
        else begin
          old = m_mem.exists(key) ? m_mem[key] : 32'h0;
          kn  = m_kn.exists(key)  ? m_kn[key]  : 4'h0;
          if (wen == 4'hF) begin
            r.due = cyc + CL; r.data = old; r.kn = kn;
            m_q.push_back(r);
          end else begin
            for (int i = 0; i < 4; i++)
              if (!wen[i]) begin old[8*i +: 8] = d[8*i +: 8]; kn[i] = 1'b1; end
            m_mem[key] = old; m_kn[key] = kn;
          end
        end
      end else m_err = 1;
    end
    cyc++;
  endtask

  task automatic nop(int n = 1);
    for (int i = 0; i < n; i++) tick(1, 1, 1, 1, 4'hF, 11'h0, 32'h0);
  endtask
  task automatic act(logic [10:0] row); tick(1, 0, 0, 1, 4'hF, row, 32'h0); endtask
  task automatic pre();                 tick(1, 0, 0, 1, 4'h0, 11'h0, 32'h0); endtask
  task automatic rd(logic [10:0] col);  tick(1, 0, 1, 0, 4'hF, col, 32'h0); endtask
  task automatic wr(logic [10:0] col, logic [31:0] d, logic [3:0] wen);
    tick(1, 0, 1, 0, wen, col, d);
  endtask
  task automatic rst_cyc(); tick(0, 1, 1, 1, 4'hF, 11'h0, 32'h0); endtask

  initial begin
    int nv;
    bus.CSn = 1; bus.RASn = 1; bus.CASn = 1; bus.WEn = 4'hF; bus.A = '0; bus.D = '0;
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    rst_cyc();
    nop();                                   // reset outputs checked here

    // write full word, read it back next cycle
    act(11'h005); nop(T_RCD - 1);
    wr(11'h010, 32'hDEADBEEF, 4'h0);
    rd(11'h010); nop(CL + 1);
    chk("t1_q", last_q, 32'hDEADBEEF);
    chk("t1_err", {31'b0, bus.ERR}, 32'h0);

    // partial write
    wr(11'h010, 32'h11223344, 4'b1010);
    rd(11'h010); nop(CL + 1);
    chk("t2_q", last_q, 32'hDE22BE44);

    // back-to-back reads
    for (int c = 0; c < 4; c++) wr(11'(c), 32'(c), 4'h0);
    nv = n_valid;
    for (int c = 0; c < 4; c++) rd(11'(c));
    nop(CL + 1);
    chk("t3_nvalid", 32'(n_valid - nv), 32'd4);
    chk("t3_last", last_q, 32'h3);

    // row isolation
    wr(11'h000, 32'h5A5A0005, 4'h0);
    pre(); nop(T_RP - 1); act(11'h006); nop(T_RCD - 1);
    wr(11'h000, 32'h66660006, 4'h0);
    rd(11'h000); nop(CL + 1);
    chk("t4_row6", last_q, 32'h66660006);
    pre(); nop(T_RP - 1); act(11'h005); nop(T_RCD - 1);
    rd(11'h000); nop(CL + 1);
    chk("t4_row5", last_q, 32'h5A5A0005);

    // READ at ACT+3
    pre(); nop(T_RP - 1); act(11'h005); nop(2);
    nv = n_valid;
    rd(11'h001); nop(CL + 1);
`ifdef DRAM_TIMING_CHECK_EN
    chk("t5_err", {31'b0, bus.ERR}, 32'h1);
    chk("t5_nvalid", 32'(n_valid - nv), 32'd0);
`else
    chk("t5_err", {31'b0, bus.ERR}, 32'h0);
    chk("t5_q", last_q, 32'h1);
`endif

    // ACT at PRE+2
    rst_cyc(); act(11'h005); nop(T_RCD - 1);
    pre(); nop(); act(11'h005); nop();
    chk("t6_err", {31'b0, bus.ERR}, (RP_M > 2) ? 32'h1 : 32'h0);

    // reset kills an in-flight read
    rst_cyc(); act(11'h005); nop(T_RCD - 1);
    nv = n_valid;
    rd(11'h000); nop(); rst_cyc(); nop(CL + 1);
    chk("t7_nvalid", 32'(n_valid - nv), 32'd0);
    chk("t7_err", {31'b0, bus.ERR}, 32'h0);
    rd(11'h000); nop();
    chk("t7_idle_rd_err", {31'b0, bus.ERR}, 32'h1);

    // random phase: initialise rows 0..3 cols 0..7, then random commands
    rst_cyc();
    for (int r = 0; r < 4; r++) begin
      act(11'(r)); nop(T_RCD - 1);
      for (int c = 0; c < 8; c++) wr(11'(c), $urandom, 4'h0);
      pre(); nop(T_RP - 1);
    end
    for (int n = 0; n < 2000; n++) begin
      int op;
      if (n % 250 == 249) begin rst_cyc(); continue; end
      op = $urandom_range(0, 19);
      if (op < 2)       act(11'($urandom_range(0, 3)));
      else if (op < 4)  pre();
      else if (op < 9)  rd(11'($urandom_range(0, 7)));
      else if (op < 13) wr(11'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 14)));
      else if (op < 19) nop();
      else              tick(1, 0, 0, 0, 4'hF, 11'h0, 32'h0);
    end
    nop(CL + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_device.md
# dram_device

- Cycle-level, synthesizable model of the single-bank SDRAM device that sits on the far side of the DRAM wrapper's DRAM interface.
- Decodes CSn/RASn/CASn/WEn commands and tracks the open row, enforcing activate/precharge timing.
- Performs byte-masked writes and returns read data CL cycles after a read command with a one-cycle VALID strobe.
- Used as the memory behind the AXI DRAM slave in system simulation, and as the reference device for wrapper verification.

## Interface
Parameters:
- ROW_BITS, 11, row address width
- COL_BITS, 10, column (word) address width; storage depth is 2^(ROW_BITS+COL_BITS) words
- T_RCD, 5, cycles from ACT to the earliest READ/WRITE
- T_RP, 5, cycles from PRE to the earliest ACT
- CL, 5, cycles from READ to data

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- CSn  in  1  chip select, active low
- RASn  in  1  row strobe, active low
- CASn  in  1  column strobe, active low
- WEn  in  4  per-byte write enable, active low
- A  in  11  address; row uses A[ROW_BITS-1:0], column uses A[COL_BITS-1:0]
- D  in  32  write data
- Q  out  32  read data, meaningful only while VALID=1
- VALID  out  1  one-cycle read-data strobe
- ERR  out  1  sticky protocol-violation flag

## Operation
Commands are decoded when CSn=0; every other input combination is NOP.
- ACT: RASn=0, CASn=1, WEn=4'hF. Opens row A[ROW_BITS-1:0].
- PRE: RASn=0, CASn=1, WEn=4'h0. Closes the open row.
- READ: RASn=1, CASn=0, WEn=4'hF. Reads word {row, A[COL_BITS-1:0]}.
- WRITE: RASn=1, CASn=0, WEn!=4'hF. Writes byte lane i from D[8i+7:8i] wherever WEn[i]=0.
- Any other combination with CSn=0 is ignored and sets ERR.

Bank FSM:
- IDLE. ACT loads the row register → ACTIVATING.
- ACTIVATING. Counts T_RCD-1 cycles → ACTIVE.
- ACTIVE. READ/WRITE accepted; PRE → PRECHARGING.
- PRECHARGING. Counts T_RP-1 cycles → IDLE.

Illegal command for the current state:
- Cases: ACT outside IDLE; READ/WRITE outside ACTIVE; PRE in ACTIVATING or PRECHARGING.
- Response: the command is ignored, state is unchanged, and ERR is set.
- PRE in IDLE is a legal NOP.

Read pipeline:
- Array data is sampled at the command edge and carried through a CL-deep valid/data shift register.
- Back-to-back READs, one per cycle, produce back-to-back VALID cycles.
- Q=0 whenever VALID=0.

Memory array:
- Contents are not reset; uninitialized words read as X.
- A WRITE in the same cycle as an in-flight READ to the same word does not alter the already-captured read data.

## Timing
- A command is presented in cycle c and sampled at the end of c.
- ACT in c: earliest legal READ/WRITE is cycle c+T_RCD.
- PRE in c: earliest legal ACT is cycle c+T_RP.
- READ in c: VALID=1 and Q=data during cycle c+CL only.
- WRITE in c: the array is updated at the end of c, so a READ in c+1 to the same word returns the new data.
- The read pipeline ignores the bank FSM: a PRE issued after a READ does not cancel data already in flight.
- Reset (rst=0 at an edge):
  - FSM → IDLE and the row register is cleared.
  - The shift register is flushed; any in-flight read data is lost.
  - Outputs: VALID=0, Q=0, ERR=0.
  - All commands sampled while rst=0 are ignored.
- ERR clears only on reset.

## Configuration
- DRAM_TIMING_CHECK_EN defined:
  - T_RCD/T_RP counters are enforced.
  - Column commands in ACTIVATING and ACT in PRECHARGING are rejected and set ERR.
- DRAM_TIMING_CHECK_EN undefined:
  - Counters are removed; ACT goes directly to ACTIVE and PRE directly to IDLE.
  - State-legality errors (e.g., ACT while ACTIVE, READ while IDLE) are still flagged.
  - CL is unaffected.

## Test plan
- Reset, ACT row 11'h005, WRITE col 10'h010 with D=32'hDEADBEEF and WEn=4'h0 at c+5, READ the same column next cycle → VALID exactly 5 cycles later with Q=32'hDEADBEEF; ERR=0.
- Partial write: WEn=4'b1010 with D=32'h11223344 over 32'hDEADBEEF → subsequent read returns 32'hDE22BE44.
- Four back-to-back READs to cols 0–3 holding 32'h0,32'h1,32'h2,32'h3 → VALID high four consecutive cycles starting CL after the first, with Q=0,1,2,3.
- READ issued 3 cycles after ACT (DRAM_TIMING_CHECK_EN defined) → no VALID, ERR=1. Same stimulus without the macro → data returned, ERR=0.
- PRE, then ACT row 11'h006 after 5 cycles; data written earlier to row 5 col 0 → a read of row 6 col 0 does not return it; re-opening row 5 returns it. ACT at PRE+2 with the macro → ERR=1.
- READ issued, rst=0 asserted 2 cycles later for one cycle → VALID never rises, Q=0, ERR=0, FSM is IDLE (READ without ACT then sets ERR).
